mlp_seq: RTL
============

MLP_SEQ -- requirements
Module: mlp_seq

Interface
REQ-001 SHALL have parameter SHIFT1, default 8, arithmetic right-shift applied to layer-1 sums before requantization.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1, inference request, sampled only in IDLE.
REQ-005 SHALL have port img_addr, output, 10, pixel index 0..783 presented to the external image buffer.
REQ-006 SHALL have port img_data, input, 8, unsigned pixel at img_addr, combinationally valid in the same cycle.
REQ-007 SHALL have port layer_sel, output, 2, weight-store select: 0 idle, 1 layer 1, 2 layer 2.
REQ-008 SHALL have port row_idx, output, 10, weight-store row: pixel index in layer 1, hidden index in layer 2.
REQ-009 SHALL have ports w1_in_packed and b1_in_packed, input, 256 each, 32 signed 8-bit lanes, lane k at bits [8k+7:8k].
REQ-010 SHALL have ports w2_in_packed and b2_in_packed, input, 80 each, 10 signed 8-bit lanes, same packing.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port pred, output, 4, predicted class 0..9.

Function
REQ-014 SHALL implement states IDLE, L1, B1, L2, B2, ARG, DONE; DONE always returns to IDLE.
REQ-015 SHALL leave IDLE for L1 on a rising edge with start=1; start in any other state SHALL be ignored.
REQ-016 SHALL, in L1, step counter n over 0..783 at one per cycle, driving img_addr=row_idx=n and layer_sel=1, and add img_data (zero-extended) times w1 lane k into 26-bit signed acc1[k] for all 32 lanes; after n=783 go to B1.
REQ-017 SHALL clear all acc1 and acc2 on the IDLE->L1 transition.
REQ-018 SHALL, in B1 (one cycle, layer_sel=1), compute h[k] = clamp((acc1[k] + sign-extended b1 lane k) >>> SHIFT1, 0, 127), giving ReLU plus saturation into 7-bit unsigned.
REQ-019 SHALL, in L2, step j over 0..31, driving row_idx=j and layer_sel=2, and add h[j] times w2 lane c into 24-bit signed acc2[c] for c=0..9; after j=31 go to B2.
REQ-020 SHALL, in B2 (one cycle, layer_sel=2), add the sign-extended b2 lane c to acc2[c].
REQ-021 SHALL, in ARG (10 cycles), scan acc2[0..9] sequentially and keep the strictly greater maximum, so ties resolve to the lowest index.
REQ-022 SHALL drive layer_sel=0, row_idx=0 and img_addr=0 in IDLE, ARG and DONE.
REQ-023 SHALL raise done in DONE only, first visible after edge 828, counting the start-sampling edge as edge 0 (L1 784, B1 1, L2 32, B2 1, ARG 10 cycles).
REQ-024 SHALL update pred on entry to DONE and hold it until the next DONE or reset.
REQ-025 SHALL rely on combinational weight, bias and image reads; no wait states are inserted.

Reset
REQ-026 SHALL, on rst low at any time including mid-inference, enter IDLE immediately and set busy=0, done=0, pred=0, layer_sel=0, row_idx=0, img_addr=0, and clear all accumulators, h and counters.
REQ-027 SHALL accept start on the first rising edge after rst is released.

Configuration
REQ-028 SHALL, when MLP_SEQ_LOGITS_EN is defined, add output logits_packed of 240 bits: 10 lanes of 24-bit acc2, valid and held from DONE until the next start, and reset to 0.
REQ-029 SHALL, when MLP_SEQ_LOGITS_EN is undefined, omit logits_packed, with all other behaviour identical.

Verification
REQ-030 SHALL cover: all-zero image, b2 lane 6 = 5, other b2 lanes 0 -> done after edge 828, pred=6.
REQ-031 SHALL cover: image all 255, w1 all 1, b1 0, SHIFT1=8 -> h[k]=clamp(199920>>>8=780)=127; w2 lane 3 = 1, other w2 lanes 0 -> pred=3 and acc2[3]=4064.
REQ-032 SHALL cover: all acc2 equal (all-zero weights and biases) -> pred=0.
REQ-033 SHALL cover: w1 all -1, image all 255 -> h all 0 (ReLU), pred equals the argmax of b2.
REQ-034 SHALL cover: rst pulsed low at cycle 400 of L1 -> busy=0 and pred=0 at once; a subsequent start completes normally in 829 cycles.
REQ-035 SHALL cover: start held high throughout a run -> no restart while busy, and a new run begins on the edge after DONE.

Source files
------------

// File: rtl/mlp_seq_if.sv
// mlp_seq_if -- request, image-buffer and weight-store signals of mlp_seq.
// The slave modport is the classifier. The master modport is the surrounding
// system (requester, image buffer, weight store).
// When MLP_SEQ_LOGITS_EN is defined, this interface also carries logits_packed.
interface mlp_seq_if;
    logic         start;
    logic [9:0]   img_addr;
    logic [7:0]   img_data;
    logic [1:0]   layer_sel;
    logic [9:0]   row_idx;
    logic [255:0] w1_in_packed;
    logic [255:0] b1_in_packed;
    logic [79:0]  w2_in_packed;
    logic [79:0]  b2_in_packed;
    logic         busy;
    logic         done;
    logic [3:0]   pred;
`ifdef MLP_SEQ_LOGITS_EN
    logic [239:0] logits_packed;

    modport master (
        output start, img_data, w1_in_packed, b1_in_packed, w2_in_packed, b2_in_packed,
        input  img_addr, layer_sel, row_idx, busy, done, pred, logits_packed
    );
    modport slave (
        input  start, img_data, w1_in_packed, b1_in_packed, w2_in_packed, b2_in_packed,
        output img_addr, layer_sel, row_idx, busy, done, pred, logits_packed
    );
`else
    modport master (
        output start, img_data, w1_in_packed, b1_in_packed, w2_in_packed, b2_in_packed,
        input  img_addr, layer_sel, row_idx, busy, done, pred
    );
    modport slave (
        input  start, img_data, w1_in_packed, b1_in_packed, w2_in_packed, b2_in_packed,
        output img_addr, layer_sel, row_idx, busy, done, pred
    );
`endif
endinterface

// File: rtl/mlp_seq.sv
// mlp_seq -- sequential two-layer MLP classifier (784 -> 32 -> 10).
// Operation per inference:
//   1. Streams one pixel per cycle into 32 hidden-layer MACs.
//   2. Requantizes the hidden sums with an arithmetic shift, ReLU and 7-bit
//      saturation.
//   3. Runs 32 cycles of 10 output-layer MACs.
//   4. Adds the output biases.
//   5. Scans the 10 logits for the lowest-index maximum.
// Optional feature: define MLP_SEQ_LOGITS_EN to expose the output-layer
// accumulators on bus.logits_packed.
module mlp_seq #(
    parameter int SHIFT1 = 8
) (
    input  logic     clk,
    input  logic     rst,
    mlp_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, L1, B1, L2, B2, ARG, DONE} state_t;

    state_t             r_state;
    logic [9:0]         r_cnt;
    logic signed [25:0] r_acc1 [32];
    logic signed [23:0] r_acc2 [10];
    logic [6:0]         r_h    [32];
    logic signed [23:0] r_best;
    logic [3:0]         r_bestIdx;
    logic               r_busy;
    logic               r_done;
    logic [3:0]         r_pred;
    logic [1:0]         r_layerSel;
    logic [9:0]         r_rowIdx;
    logic [9:0]         r_imgAddr;

    logic signed [16:0] w_pixExt;
    logic signed [16:0] w_w1Ext [32];
    logic signed [16:0] w_prod1 [32];
    logic signed [25:0] w_sum1  [32];
    logic signed [25:0] w_shr1  [32];
    logic [6:0]         w_hNext [32];
    logic [6:0]         w_hSel;
    logic signed [15:0] w_hExt;
    logic signed [15:0] w_w2Ext [10];
    logic signed [15:0] w_prod2 [10];
    logic signed [23:0] w_argVal;
    logic               w_take;

    // Lane products, hidden-layer requantization and the argmax candidate for the current count
    always_comb begin
        w_pixExt = {9'd0, bus.img_data};
        w_hSel   = r_h[r_cnt[4:0]];
        w_hExt   = {9'd0, w_hSel};
        w_argVal = '0;
        for (int k = 0; k < 32; k++) begin
            w_w1Ext[k] = {{9{bus.w1_in_packed[8*k+7]}}, bus.w1_in_packed[8*k +: 8]};
            w_prod1[k] = w_pixExt * w_w1Ext[k];
            w_sum1[k]  = r_acc1[k] + {{18{bus.b1_in_packed[8*k+7]}}, bus.b1_in_packed[8*k +: 8]};
            w_shr1[k]  = w_sum1[k] >>> SHIFT1;
            if (w_shr1[k] < 26'sd0) begin
                w_hNext[k] = 7'd0;
            end else if (w_shr1[k] > 26'sd127) begin
                w_hNext[k] = 7'd127;
            end else begin
                w_hNext[k] = w_shr1[k][6:0];
            end
        end
        for (int c = 0; c < 10; c++) begin
            w_w2Ext[c] = {{8{bus.w2_in_packed[8*c+7]}}, bus.w2_in_packed[8*c +: 8]};
            w_prod2[c] = w_hExt * w_w2Ext[c];
            if (r_cnt[3:0] == 4'(c)) begin
                w_argVal = r_acc2[c];
            end
        end
        // Only a strictly greater logit displaces the current best, so ties keep the lowest index
        w_take = (r_cnt == 10'd0) || (w_argVal > r_best);
    end

    // Sequencer: walks the layers, owns every accumulator and drives all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_best     <= '0;
            r_bestIdx  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pred     <= '0;
            r_layerSel <= '0;
            r_rowIdx   <= '0;
            r_imgAddr  <= '0;
            for (int k = 0; k < 32; k++) begin
                r_acc1[k] <= '0;
                r_h[k]    <= '0;
            end
            for (int c = 0; c < 10; c++) begin
                r_acc2[c] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= L1;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_layerSel <= 2'd1;
                        r_rowIdx   <= '0;
                        r_imgAddr  <= '0;
                        for (int k = 0; k < 32; k++) begin
                            r_acc1[k] <= '0;
                        end
                        for (int c = 0; c < 10; c++) begin
                            r_acc2[c] <= '0;
                        end
                    end
                end
                L1: begin
                    for (int k = 0; k < 32; k++) begin
                        r_acc1[k] <= r_acc1[k] + {{9{w_prod1[k][16]}}, w_prod1[k]};
                    end
                    if (r_cnt == 10'd783) begin
                        r_state   <= B1;
                        r_cnt     <= '0;
                        r_rowIdx  <= '0;
                        r_imgAddr <= '0;
                    end else begin
                        r_cnt     <= r_cnt + 10'd1;
                        r_rowIdx  <= r_cnt + 10'd1;
                        r_imgAddr <= r_cnt + 10'd1;
                    end
                end
                B1: begin
                    for (int k = 0; k < 32; k++) begin
                        r_h[k] <= w_hNext[k];
                    end
                    r_state    <= L2;
                    r_cnt      <= '0;
                    r_rowIdx   <= '0;
                    r_layerSel <= 2'd2;
                end
                L2: begin
                    for (int c = 0; c < 10; c++) begin
                        r_acc2[c] <= r_acc2[c] + {{8{w_prod2[c][15]}}, w_prod2[c]};
                    end
                    if (r_cnt == 10'd31) begin
                        r_state  <= B2;
                        r_cnt    <= '0;
                        r_rowIdx <= '0;
                    end else begin
                        r_cnt    <= r_cnt + 10'd1;
                        r_rowIdx <= r_cnt + 10'd1;
                    end
                end
                B2: begin
                    for (int c = 0; c < 10; c++) begin
                        r_acc2[c] <= r_acc2[c] + {{16{bus.b2_in_packed[8*c+7]}}, bus.b2_in_packed[8*c +: 8]};
                    end
                    r_state    <= ARG;
                    r_cnt      <= '0;
                    r_layerSel <= 2'd0;
                end
                ARG: begin
                    if (w_take) begin
                        r_best    <= w_argVal;
                        r_bestIdx <= r_cnt[3:0];
                    end
                    if (r_cnt == 10'd9) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_pred  <= w_take ? 4'd9 : r_bestIdx;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pred      = r_pred;
    assign bus.layer_sel = r_layerSel;
    assign bus.row_idx   = r_rowIdx;
    assign bus.img_addr  = r_imgAddr;

`ifdef MLP_SEQ_LOGITS_EN
    // Expose the output accumulators. They hold from DONE until the next start clears them.
    always_comb begin
        bus.logits_packed = '0;
        for (int c = 0; c < 10; c++) begin
            bus.logits_packed[24*c +: 24] = r_acc2[c];
        end
    end
`endif
endmodule
